// File: rtl/vec_reduce_acc.sv
// Vector reduce-and-accumulate: sums each beat's elements, accumulates per frame, emits one result per frame.
// Define VEC_REDUCE_ACC_SAT_EN to clamp results to BW_O (with sat_o); otherwise results wrap.
module vec_reduce_acc #(
    parameter int BW_I       = 16,
    parameter int VECTOR_LEN = 13,
    parameter int ACC_BW     = 32,
    parameter int BW_O       = 24,
    parameter int CNT_BW     = 8
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [VECTOR_LEN*BW_I-1:0] data_i,
    input  logic                       valid_i,
    input  logic                       last_i,
    output logic                       ready_o,
    output logic [BW_O-1:0]            data_o,
    output logic [CNT_BW-1:0]          cnt_o,
    output logic                       valid_o,
    input  logic                       ready_i,
    output logic                       sat_o
);

    typedef enum logic {ACCUM, HOLD} state_t;

    localparam logic [CNT_BW-1:0] CNT_MAX = {CNT_BW{1'b1}};

    state_t              state_q, state_d;
    logic [ACC_BW-1:0]   acc_q, acc_d;
    logic [CNT_BW-1:0]   beat_cnt_q, beat_cnt_d;
    logic [BW_O-1:0]     data_q, data_d;
    logic [CNT_BW-1:0]   cnt_q, cnt_d;

    logic [ACC_BW-1:0]   beat_sum;
    logic [ACC_BW-1:0]   total;
    logic [CNT_BW-1:0]   cnt_inc;
    logic [BW_O-1:0]     conv;
    logic                accept;

    assign valid_o = (state_q == HOLD);
    // Ready is a pure function of the output stage so upstream never sees a valid_i loop.
    assign ready_o = !valid_o || ready_i;
    assign accept  = valid_i && ready_o;
    assign data_o  = data_q;
    assign cnt_o   = cnt_q;

    always_comb begin
        beat_sum = '0;
        for (int k = 0; k < VECTOR_LEN; k++) begin
            beat_sum = beat_sum + {{(ACC_BW-BW_I){data_i[k*BW_I+BW_I-1]}}, data_i[k*BW_I +: BW_I]};
        end
    end

    assign total   = acc_q + beat_sum;
    assign cnt_inc = (beat_cnt_q == CNT_MAX) ? CNT_MAX : beat_cnt_q + CNT_BW'(1);

`ifdef VEC_REDUCE_ACC_SAT_EN
    localparam logic [ACC_BW-1:0] SAT_MAX = {{(ACC_BW-BW_O+1){1'b0}}, {(BW_O-1){1'b1}}};
    localparam logic [ACC_BW-1:0] SAT_MIN = {{(ACC_BW-BW_O+1){1'b1}}, {(BW_O-1){1'b0}}};

    logic sat_q, sat_d;
    logic conv_sat;

    always_comb begin
        conv_sat = 1'b1;
        if ($signed(total) > $signed(SAT_MAX)) begin
            conv = BW_O'(SAT_MAX);
        end else if ($signed(total) < $signed(SAT_MIN)) begin
            conv = BW_O'(SAT_MIN);
        end else begin
            conv     = BW_O'(total);
            conv_sat = 1'b0;
        end
    end

    always_comb begin
        sat_d = sat_q;
        if (accept && last_i) begin
            sat_d = conv_sat;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sat_q <= 1'b0;
        end else begin
            sat_q <= sat_d;
        end
    end

    assign sat_o = sat_q;
`else
    assign conv  = BW_O'(total);
    assign sat_o = 1'b0;
`endif

    // NOTE: every variable gets its hold value first, so no path through this block can infer a latch.
    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        beat_cnt_d = beat_cnt_q;
        data_d     = data_q;
        cnt_d      = cnt_q;

        if (state_q == HOLD && ready_i) begin
            state_d = ACCUM;
        end

        // A last beat in HOLD overrides the return to ACCUM so back-to-back results have no bubble.
        if (accept) begin
            if (last_i) begin
                data_d     = conv;
                cnt_d      = cnt_inc;
                acc_d      = '0;
                beat_cnt_d = '0;
                state_d    = HOLD;
            end else begin
                acc_d      = total;
                beat_cnt_d = cnt_inc;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= ACCUM;
            acc_q      <= '0;
            beat_cnt_q <= '0;
            data_q     <= '0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            beat_cnt_q <= beat_cnt_d;
            data_q     <= data_d;
            cnt_q      <= cnt_d;
        end
    end

endmodule
